// File: rtl/beat_gen_prog.sv
`timescale 1ns/1ps
// beat_gen_prog: programmable tempo / beat generator.
//
// Divides the sample-rate strobe count_en into a beat pulse and a measure
// pulse. The beat period and beats-per-measure can be changed at run time.
// A new value waits in a pending register and takes effect at the next beat
// boundary or sync, so the beat that is already running is never cut short.
//
// Optional feature macro: BEAT_GEN_SWING_EN
//   When this macro is defined, the swing_in port and a swing register exist.
//   Even-indexed beats are lengthened by the swing amount and odd-indexed
//   beats are shortened by the same amount.
//
// Ports:
//   clk         system clock
//   reset       synchronous reset, active-low
//   count_en    sample strobe; each high cycle is one count step
//   run         1 = counting, 0 = paused (count and beat_idx hold)
//   sync        restart the beat phase at beat 0 (works while paused)
//   period_in   new period, in count_en strobes per beat
//   bpm_in      new beats-per-measure value
//   period_ld   load request for period_in / bpm_in (and swing_in)
//   swing_in    swing offset (only with BEAT_GEN_SWING_EN)
//   beat        one-clk pulse at each beat boundary (registered)
//   measure     one-clk pulse together with beat when beat_idx returns to 0
//   beat_idx    index of the current beat, 0..bpm-1
//   count       current position within the beat
//   period_cur  period currently in effect
//   ld_pending  a load has been accepted but not yet applied
//
// Control semantics: period_ld has no ready. The block accepts a load on
// every cycle it is high, and the last write before a transfer wins. The
// transfer happens on the next wrap or sync. If period_ld is high in the same
// cycle as the wrap or sync, the values on the inputs are used directly.
module beat_gen_prog #(
   parameter int SIGNAL_WIDTH   = 16,
   parameter int BPM_WIDTH      = 4,
   parameter int DEFAULT_PERIOD = 4800,
   parameter int DEFAULT_BPM    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    count_en,
   input  logic                    run,
   input  logic                    sync,
   input  logic [SIGNAL_WIDTH-1:0] period_in,
   input  logic [BPM_WIDTH-1:0]    bpm_in,
   input  logic                    period_ld,
`ifdef BEAT_GEN_SWING_EN
   input  logic [SIGNAL_WIDTH-1:0] swing_in,
`endif
   output logic                    beat,
   output logic                    measure,
   output logic [BPM_WIDTH-1:0]    beat_idx,
   output logic [SIGNAL_WIDTH-1:0] count,
   output logic [SIGNAL_WIDTH-1:0] period_cur,
   output logic                    ld_pending
);

   localparam int SW = SIGNAL_WIDTH;
   localparam int BW = BPM_WIDTH;

   logic [BW-1:0] bpm_cur;
   logic [SW-1:0] pend_period;
   logic [BW-1:0] pend_bpm;

   logic [SW-1:0] eff_period;
   logic [SW-1:0] beat_len;
   logic          step;
   logic          wrap;
   logic          apply;
   logic [SW-1:0] new_period;
   logic [BW-1:0] new_bpm;
   logic [BW-1:0] next_bpm;
   logic [BW:0]   next_bpm_eff;
   logic [BW:0]   idx_inc;
   logic [BW-1:0] idx_next;

   // A period of 0 behaves as 1, so every step produces a beat.
   assign eff_period = (period_cur == '0) ? SW'(1) : period_cur;

`ifdef BEAT_GEN_SWING_EN
   logic [SW-1:0] swing_cur;
   logic [SW-1:0] pend_swing;
   logic [SW-1:0] new_swing;
   logic [SW-1:0] swing_eff;
   logic [SW:0]   even_sum;

   // Clamp the swing so that an odd beat always lasts at least one step.
   assign swing_eff = (swing_cur >= eff_period) ? (eff_period - SW'(1)) : swing_cur;
   assign even_sum  = {1'b0, eff_period} + {1'b0, swing_eff};
   // The length of an even beat saturates at the largest counter value.
   assign beat_len  = beat_idx[0] ? (eff_period - swing_eff)
                                  : (even_sum[SW] ? {SW{1'b1}} : even_sum[SW-1:0]);
   assign new_swing = period_ld ? swing_in : pend_swing;
`else
   assign beat_len = eff_period;
`endif

   assign step = count_en & run;
   assign wrap = step & (count == (beat_len - SW'(1)));

   // Values that a transfer would install. A load arriving in the same cycle
   // bypasses the pending register.
   assign new_period = period_ld ? period_in : pend_period;
   assign new_bpm    = period_ld ? bpm_in    : pend_bpm;
   assign apply      = (wrap | sync) & (period_ld | ld_pending);

   // The next index is computed against the bpm of the beat that is
   // starting. If the bpm shrinks below the current index, the index folds
   // back to 0 and measure pulses.
   assign next_bpm     = apply ? new_bpm : bpm_cur;
   assign next_bpm_eff = (next_bpm == '0) ? (BW+1)'(1) : {1'b0, next_bpm};
   assign idx_inc      = {1'b0, beat_idx} + (BW+1)'(1);
   assign idx_next     = (idx_inc >= next_bpm_eff) ? '0 : idx_inc[BW-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         count       <= '0;
         beat_idx    <= '0;
         beat        <= 1'b0;
         measure     <= 1'b0;
         ld_pending  <= 1'b0;
         period_cur  <= SW'(DEFAULT_PERIOD);
         bpm_cur     <= BW'(DEFAULT_BPM);
         pend_period <= '0;
         pend_bpm    <= '0;
`ifdef BEAT_GEN_SWING_EN
         swing_cur   <= '0;
         pend_swing  <= '0;
`endif
      end else begin
         beat    <= sync | wrap;
         measure <= sync | (wrap & (idx_next == '0));

         // sync has priority over both the wrap and a plain step.
         if (sync) begin
            count    <= '0;
            beat_idx <= '0;
         end else if (wrap) begin
            count    <= '0;
            beat_idx <= idx_next;
         end else if (step) begin
            count    <= count + SW'(1);
         end

         if (apply) begin
            period_cur <= new_period;
            bpm_cur    <= new_bpm;
`ifdef BEAT_GEN_SWING_EN
            swing_cur  <= new_swing;
`endif
         end

         if (apply) begin
            ld_pending <= 1'b0;
         end else if (period_ld) begin
            ld_pending <= 1'b1;
         end

         if (period_ld) begin
            pend_period <= period_in;
            pend_bpm    <= bpm_in;
`ifdef BEAT_GEN_SWING_EN
            pend_swing  <= swing_in;
`endif
         end
      end
   end

endmodule

// File: tb/tb_beat_gen_prog.sv
`timescale 1ns/1ps
// Testbench for beat_gen_prog. The DUT is built with DEFAULT_PERIOD=4 and
// DEFAULT_BPM=3. A table of single-cycle vectors covers free-running and a
// deferred load. Hand-written sequences cover sparse strobes, pause, sync,
// period 0, bpm shrink, reset with a pending load and, when enabled, swing.
module tb_beat_gen_prog;

   localparam int SW = 16;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          count_en;
   logic          run;
   logic          sync;
   logic [SW-1:0] period_in;
   logic [BW-1:0] bpm_in;
   logic          period_ld;
   logic [SW-1:0] swing_in;
   logic          beat;
   logic          measure;
   logic [BW-1:0] beat_idx;
   logic [SW-1:0] count;
   logic [SW-1:0] period_cur;
   logic          ld_pending;

   int checks   = 0;
   int failures = 0;
   int phase    = 0;
   bit sparse   = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   beat_gen_prog #(
      .SIGNAL_WIDTH(SW), .BPM_WIDTH(BW), .DEFAULT_PERIOD(4), .DEFAULT_BPM(3)
   ) dut (
      .clk(clk), .reset(reset), .count_en(count_en), .run(run), .sync(sync),
      .period_in(period_in), .bpm_in(bpm_in), .period_ld(period_ld),
`ifdef BEAT_GEN_SWING_EN
      .swing_in(swing_in),
`endif
      .beat(beat), .measure(measure), .beat_idx(beat_idx), .count(count),
      .period_cur(period_cur), .ld_pending(ld_pending)
   );

   // ---------------- driver tasks ----------------
   // Outputs are sampled and inputs changed 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      phase++;
      if (sparse) count_en = (phase % 3 == 0);
   endtask

   task automatic idle_inputs();
      count_en  = 1'b1;
      run       = 1'b1;
      sync      = 1'b0;
      period_ld = 1'b0;
      period_in = '0;
      bpm_in    = '0;
      swing_in  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic load(input logic [SW-1:0] p, input logic [BW-1:0] b,
                       input logic [SW-1:0] s);
      period_ld = 1'b1;
      period_in = p;
      bpm_in    = b;
      swing_in  = s;
      tick();
      period_ld = 1'b0;
   endtask

   // Counts clocks until the next beat pulse; a timeout yields 200.
   task automatic measure_gap(output int gap);
      gap = 0;
      do begin
         tick();
         gap++;
      end while (!beat && gap < 200);
   endtask

   // ---------------- scoreboard ----------------
   function automatic logic [38:0] obs();
      return {beat, measure, beat_idx, count, period_cur, ld_pending};
   endfunction

   function automatic logic [38:0] expv(logic b, logic m, logic [BW-1:0] idx,
                                        logic [SW-1:0] cnt, logic [SW-1:0] pc,
                                        logic pend);
      return {b, m, idx, cnt, pc, pend};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic          ld;
      logic [SW-1:0] pin;
      logic [BW-1:0] bin;
      logic [38:0]   exp;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(logic ld, logic [SW-1:0] pin, logic [BW-1:0] bin,
                               logic [38:0] e);
      vec_t v;
      v.ld  = ld;
      v.pin = pin;
      v.bin = bin;
      v.exp = e;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int g2;

      // Free-run with period 4 and bpm 3, then a deferred load of period 6
      // at count 1.
      tbl[0]  = mk(0, 0, 0, expv(0, 0, 0, 1, 4, 0));
      tbl[1]  = mk(0, 0, 0, expv(0, 0, 0, 2, 4, 0));
      tbl[2]  = mk(0, 0, 0, expv(0, 0, 0, 3, 4, 0));
      tbl[3]  = mk(0, 0, 0, expv(1, 0, 1, 0, 4, 0));
      tbl[4]  = mk(0, 0, 0, expv(0, 0, 1, 1, 4, 0));
      tbl[5]  = mk(0, 0, 0, expv(0, 0, 1, 2, 4, 0));
      tbl[6]  = mk(0, 0, 0, expv(0, 0, 1, 3, 4, 0));
      tbl[7]  = mk(0, 0, 0, expv(1, 0, 2, 0, 4, 0));
      tbl[8]  = mk(0, 0, 0, expv(0, 0, 2, 1, 4, 0));
      tbl[9]  = mk(1, 6, 3, expv(0, 0, 2, 2, 4, 1));
      tbl[10] = mk(0, 0, 0, expv(0, 0, 2, 3, 4, 1));
      tbl[11] = mk(0, 0, 0, expv(1, 1, 0, 0, 6, 0));
      for (int i = 12; i < 17; i++)
         tbl[i] = mk(0, 0, 0, expv(0, 0, 0, 16'(i - 11), 6, 0));
      tbl[17] = mk(0, 0, 0, expv(1, 0, 1, 0, 6, 0));

      // Reset state
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      chk("reset_state", 64'(obs()), 64'(expv(0, 0, 0, 0, 4, 0)));
      reset = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 18; i++) begin
         period_ld = tbl[i].ld;
         period_in = tbl[i].pin;
         bpm_in    = tbl[i].bin;
         tick();
         chk($sformatf("vec[%0d]", i), 64'(obs()), 64'(tbl[i].exp));
      end
      period_ld = 1'b0;

      // A sparse strobe (every 3rd clk) with period 4 gives a beat every 12 clks.
      do_reset();
      sparse = 1'b1;
      measure_gap(gap);
      measure_gap(gap);
      chk("sparse_gap1", 64'(gap), 64'd12);
      measure_gap(gap);
      chk("sparse_gap2", 64'(gap), 64'd12);
      sparse   = 1'b0;
      count_en = 1'b1;

      // Pausing for 10 clks stretches that one beat from 4 to 14 clks.
      do_reset();
      measure_gap(gap);
      chk("pause_first_gap", 64'(gap), 64'd4);
      tick();
      run = 1'b0;
      repeat (10) tick();
      chk("pause_hold_count", 64'(count), 64'd1);
      run = 1'b1;
      measure_gap(gap);
      chk("pause_stretched_gap", 64'(gap + 11), 64'd14);
      measure_gap(gap);
      chk("pause_next_gap", 64'(gap), 64'd4);

      // A sync in mid-beat restarts the phase at beat 0.
      do_reset();
      repeat (6) tick();
      chk("sync_pre", 64'(obs()), 64'(expv(0, 0, 1, 2, 4, 0)));
      sync = 1'b1;
      tick();
      sync = 1'b0;
      chk("sync_restart", 64'(obs()), 64'(expv(1, 1, 0, 0, 4, 0)));
      measure_gap(gap);
      chk("sync_next_gap", 64'(gap), 64'd4);
      sync = 1'b1;
      load(5, 3, 0);
      sync = 1'b0;
      chk("sync_with_load", 64'(obs()), 64'(expv(1, 1, 0, 0, 5, 0)));
      measure_gap(gap);
      chk("sync_load_gap", 64'(gap), 64'd5);
      run = 1'b0;
      tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      chk("sync_while_paused", 64'({beat, measure, count}), 64'({1'b1, 1'b1, 16'd0}));
      run = 1'b1;

      // Period 0 gives a beat on every step once the load is transferred.
      do_reset();
      load(0, 3, 0);
      chk("p0_pending", 64'(obs()), 64'(expv(0, 0, 0, 1, 4, 1)));
      tick();
      tick();
      tick();
      chk("p0_transfer", 64'(obs()), 64'(expv(1, 0, 1, 0, 0, 0)));
      tick();
      chk("p0_step2", 64'(obs()), 64'(expv(1, 0, 2, 0, 0, 0)));
      tick();
      chk("p0_step3", 64'(obs()), 64'(expv(1, 1, 0, 0, 0, 0)));

      // When bpm shrinks to 2 with beat_idx at 2, the index folds back to 0.
      do_reset();
      repeat (8) tick();
      load(4, 2, 0);
      tick();
      tick();
      tick();
      chk("bpm_shrink", 64'(obs()), 64'(expv(1, 1, 0, 0, 4, 0)));

      // Reset with a pending load discards the load.
      do_reset();
      load(9, 3, 0);
      tick();
      tick();
      chk("rst_pre", 64'(obs()), 64'(expv(0, 0, 0, 3, 4, 1)));
      reset = 1'b0;
      tick();
      chk("rst_mid_beat", 64'(obs()), 64'(expv(0, 0, 0, 0, 4, 0)));
      reset = 1'b1;
      measure_gap(gap);
      chk("rst_gap_default", 64'(gap), 64'd4);

`ifdef BEAT_GEN_SWING_EN
      // Period 8 with swing 2: odd beats last 6 clks and even beats 10.
      do_reset();
      load(8, 4, 2);
      measure_gap(gap);
      chk("swing_load_gap", 64'(gap + 1), 64'd4);
      measure_gap(gap);
      chk("swing_g1", 64'(gap), 64'd6);
      measure_gap(gap);
      chk("swing_g2", 64'(gap), 64'd10);
      measure_gap(gap);
      chk("swing_g3", 64'(gap), 64'd6);
      measure_gap(gap);
      chk("swing_g4", 64'(gap), 64'd10);
      // Swing 9 is clamped to 7, which gives beats of 15 and 1 clks.
      load(8, 4, 9);
      measure_gap(g2);
      chk("swing_clamp_cur", 64'(g2 + 1), 64'd6);
      measure_gap(gap);
      chk("swing_clamp_even", 64'(gap), 64'd15);
      measure_gap(gap);
      chk("swing_clamp_odd", 64'(gap), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
